// File: rtl/comparator_serial_lsb_if.sv
// Handshake/operand bundle for the bit-serial comparator.
// master drives the request side, slave is the comparator.
interface comparator_serial_lsb_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             e;
  logic             g;
  logic             l;

  modport master (output start, a, b, input  busy, done, e, g, l);
  modport slave  (input  start, a, b, output busy, done, e, g, l);
endinterface

// File: rtl/comparator_serial_lsb.sv
// Bit-serial unsigned magnitude comparator, LSB first: one bit per clock,
// and each more-significant bit overrides the verdict of the lower ones.
module comparator_serial_lsb #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  comparator_serial_lsb_if.slave io
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wg_q, wg_d, wl_q, wl_d;
  logic             done_q, done_d;
  logic             e_q, e_d, g_q, g_d, l_q, l_d;
  logic             wg_n, wl_n;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    wg_d    = wg_q;
    wl_d    = wl_q;
    done_d  = 1'b0;
    e_d     = e_q;
    g_d     = g_q;
    l_d     = l_q;

    // Verdict after folding in the current bit pair; equal bits keep the old one.
    wg_n = wg_q;
    wl_n = wl_q;
    if (sa_q[0] && !sb_q[0]) begin
      wg_n = 1'b1;
      wl_n = 1'b0;
    end else if (!sa_q[0] && sb_q[0]) begin
      wg_n = 1'b0;
      wl_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (io.start) begin
          sa_d    = io.a;
          sb_d    = io.b;
          wg_d    = 1'b0;
          wl_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        wg_d  = wg_n;
        wl_d  = wl_n;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Hold the counter on the last bit so it never wraps.
          cnt_d   = cnt_q;
          g_d     = wg_n;
          l_d     = wl_n;
          e_d     = ~(wg_n | wl_n);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      wg_q    <= 1'b0;
      wl_q    <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      wg_q    <= wg_d;
      wl_q    <= wl_d;
      done_q  <= done_d;
      e_q     <= e_d;
      g_q     <= g_d;
      l_q     <= l_d;
    end
  end

  assign io.busy = (state_q == SHIFT);
  assign io.done = done_q;
  assign io.e    = e_q;
  assign io.g    = g_q;
  assign io.l    = l_q;
endmodule

// File: tb/tb_comparator_serial_lsb.sv
// Random and directed bench for comparator_serial_lsb at WIDTH=8 and WIDTH=2,
// checked against a plain a==b / a>b / a<b reference with cycle-exact timing.
module tb_comparator_serial_lsb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] exp_egl [2];   // [0]: WIDTH=8 unit, [1]: WIDTH=2 unit

  always #5 clk = ~clk;

  comparator_serial_lsb_if #(.WIDTH(8)) i8 ();
  comparator_serial_lsb_if #(.WIDTH(2)) i2 ();

  comparator_serial_lsb #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .io(i8.slave));
  comparator_serial_lsb #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .io(i2.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_egl(input longint unsigned x, input longint unsigned y);
    return {x == y, x > y, x < y};
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [7:0] av, input logic [7:0] bv);
    if (sel == 2) begin
      i2.start = st; i2.a = av[1:0]; i2.b = bv[1:0];
    end else begin
      i8.start = st; i8.a = av;      i8.b = bv;
    end
  endtask

  // {busy, done, e, g, l}
  function automatic logic [4:0] obs(input int sel);
    if (sel == 2) return {i2.busy, i2.done, i2.e, i2.g, i2.l};
    return {i8.busy, i8.done, i8.e, i8.g, i8.l};
  endfunction

  // One full comparison; start/a/b are randomized throughout SHIFT and must be ignored.
  task automatic cmp(input int sel, input logic [7:0] av, input logic [7:0] bv);
    int         w;
    int         x;
    logic [7:0] am, bm;
    logic [4:0] o;
    w  = (sel == 2) ? 2 : 8;
    x  = (sel == 2) ? 1 : 0;
    am = (sel == 2) ? {6'b0, av[1:0]} : av;
    bm = (sel == 2) ? {6'b0, bv[1:0]} : bv;
    @(negedge clk);
    o = obs(sel);
    chk("idle", 64'(o), 64'({2'b00, exp_egl[x]}));
    set_in(sel, 1'b1, av, bv);
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      o = obs(sel);
      chk("shift_hold", 64'(o), 64'({2'b10, exp_egl[x]}));
      set_in(sel, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    o = obs(sel);
    exp_egl[x] = ref_egl(64'(am), 64'(bm));
    chk("done", 64'(o), 64'({2'b01, exp_egl[x]}));
    chk("onehot", 64'($countones(o[2:0])), 64'd1);
    set_in(sel, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  logic [7:0] pa [3] = '{8'h33, 8'hA0, 8'h7E};
  logic [7:0] pb [3] = '{8'h33, 8'h9F, 8'h7F};

  initial begin
    logic [4:0] o;
    int c;
    exp_egl[0] = 3'b000;
    exp_egl[1] = 3'b000;
    set_in(8, 1'b0, 8'h00, 8'h00);
    set_in(2, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst8", 64'(obs(8)), 64'd0);
    chk("rst2", 64'(obs(2)), 64'd0);
    rst = 1'b0;

    cmp(8, 8'h5A, 8'h5A);
    cmp(8, 8'h80, 8'h7F);
    cmp(8, 8'h01, 8'h02);
    cmp(8, 8'h10, 8'h20);
    cmp(8, 8'hFF, 8'h00);   // l must hold through SHIFT, then g
    cmp(8, 8'h00, 8'hFF);
    cmp(8, 8'hFF, 8'hFF);
    cmp(8, 8'hFE, 8'hFF);

    // start held high: a result every WIDTH+1 cycles, operands re-captured each time
    @(negedge clk);
    set_in(8, 1'b1, pa[0], pb[0]);
    for (int r = 0; r < 3; r++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
        o = obs(8);
        chk("busy_done_excl", 64'(o[4] & o[3]), 64'd0);
      end while (!o[3] && c < 20);
      chk("b2b_lat", 64'(c), 64'd9);
      exp_egl[0] = ref_egl(64'(pa[r]), 64'(pb[r]));
      chk("b2b_res", 64'(o[2:0]), 64'(exp_egl[0]));
      if (r < 2) set_in(8, 1'b1, pa[r+1], pb[r+1]);
      else       set_in(8, 1'b0, 8'h00, 8'h00);
    end

    // reset mid-SHIFT: outputs clear at once, no done afterwards
    @(negedge clk);
    set_in(8, 1'b1, 8'hC3, 8'h3C);
    repeat (4) begin
      @(negedge clk);
      set_in(8, 1'b0, 8'h00, 8'h00);
    end
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'(obs(8)), 64'd0);
    exp_egl[0] = 3'b000;
    exp_egl[1] = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(obs(8)), 64'd0);
    end
    cmp(8, 8'h00, 8'h00);

    for (int n = 0; n < 1000; n++) cmp(8, 8'($urandom), 8'($urandom));
    for (int n = 0; n < 1000; n++) cmp(2, 8'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
